// File: rtl/touch_pkg.sv
// touch_pkg: shared ADC width, FSM state encoding and default screen size for the touch sampler
package touch_pkg;
  localparam int ADC_W = 12;
  localparam int SCREEN_W_DEF = 240;
  localparam int SCREEN_H_DEF = 320;
  typedef enum logic [1:0] {IDLE, ACCUM, SCALE, OUT} state_t;
endpackage

// File: rtl/touch_sample_controller_div.sv
// touch_sample_controller_div: free-running counter 0..MAX_VALUE, tick high while at MAX_VALUE
module touch_sample_controller_div #(
  parameter int MAX_VALUE = 24
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);
  localparam int CW = $clog2(MAX_VALUE + 2);
  logic [CW-1:0] cnt;
  assign tick = cnt == CW'(MAX_VALUE);
  // wrap at MAX_VALUE so the tick repeats every MAX_VALUE+1 cycles
  always_ff @(posedge clk)
    if (reset) cnt <= '0;
    else cnt <= tick ? '0 : cnt + CW'(1);
endmodule

// File: rtl/touch_sample_controller.sv
// touch_sample_controller: drives AD7843 enable, batches/filters samples, tracks strokes; TOUCH_SCALE_EN adds pixel scaling
module touch_sample_controller
  import touch_pkg::*;
#(
  parameter int CLK_DIV = 25,
  parameter int AVG_LOG2 = 2,
  parameter int MAX_DELTA = 64,
  parameter int IDLE_TIMEOUT = 20000
`ifdef TOUCH_SCALE_EN
  ,
  parameter int SCREEN_W = SCREEN_W_DEF,
  parameter int SCREEN_H = SCREEN_H_DEF
`endif
) (
  input  logic              clk,
  input  logic              reset,
  output logic              drv_en,
  input  logic              drv_pos_ready,
  input  logic [ADC_W-1:0]  drv_x_pos,
  input  logic [ADC_W-1:0]  drv_y_pos,
  output logic              pt_valid,
  input  logic              pt_ready,
  output logic [ADC_W-1:0]  pt_x,
  output logic [ADC_W-1:0]  pt_y,
  output logic              pen_down,
  output logic              stroke_end
);
  localparam int SW = ADC_W + AVG_LOG2;
  localparam int NW = AVG_LOG2 + 1;
  localparam int TW = $clog2(IDLE_TIMEOUT + 1);
`ifdef TOUCH_SCALE_EN
  localparam int PW = ADC_W + 16;
  localparam state_t DONE = SCALE;
`else
  localparam state_t DONE = OUT;
`endif
  state_t state, state_n;
  logic prev_ready, evt, tmo_sat, outlier, load, add, last, stroke, take;
  logic [ADC_W-1:0] ref_x, ref_y, dx, dy;
  logic [SW-1:0] sum_x, sum_y, sum_nx, sum_ny;
  logic [NW-1:0] n;
  logic [TW-1:0] tmo;

  touch_sample_controller_div #(.MAX_VALUE(CLK_DIV - 1)) u_div (
    .clk(clk),
    .reset(reset),
    .tick(drv_en)
  );

  assign evt = drv_pos_ready & ~prev_ready;
  assign dx = drv_x_pos > ref_x ? drv_x_pos - ref_x : ref_x - drv_x_pos;
  assign dy = drv_y_pos > ref_y ? drv_y_pos - ref_y : ref_y - drv_y_pos;
  assign outlier = dx > ADC_W'(MAX_DELTA) || dy > ADC_W'(MAX_DELTA);
  assign sum_nx = sum_x + SW'(drv_x_pos);
  assign sum_ny = sum_y + SW'(drv_y_pos);
  assign last = n == NW'((1 << AVG_LOG2) - 1);
  assign tmo_sat = tmo == TW'(IDLE_TIMEOUT);
  assign pt_valid = state == OUT;
  assign take = pt_valid & pt_ready;

  // state register
  always_ff @(posedge clk)
    if (reset) state <= IDLE;
    else state <= state_n;

  // next state and datapath controls; an event in ACCUM always beats the timeout
  always_comb begin
    state_n = state;
    load = 1'b0;
    add = 1'b0;
    stroke = 1'b0;
    case (state)
      IDLE: begin
        load = evt;
        state_n = evt ? ACCUM : IDLE;
      end
      ACCUM:
        if (evt) begin
          load = n == '0 || outlier;
          add = !load;
          state_n = add && last ? DONE : ACCUM;
        end else if (pen_down && tmo_sat) begin
          stroke = 1'b1;
          state_n = IDLE;
        end
      SCALE: state_n = OUT;
      OUT: state_n = take ? ACCUM : OUT;
      default: state_n = IDLE;
    endcase
  end

  // sample edge detect, timeout, accumulators, pen tracking and point output registers
  always_ff @(posedge clk)
    if (reset) begin
      prev_ready <= 1'b0;
      tmo <= '0;
      ref_x <= '0;
      ref_y <= '0;
      sum_x <= '0;
      sum_y <= '0;
      n <= '0;
      pen_down <= 1'b0;
      stroke_end <= 1'b0;
      pt_x <= '0;
      pt_y <= '0;
    end else begin
      prev_ready <= drv_pos_ready;
      tmo <= evt ? '0 : tmo + TW'(drv_en && !tmo_sat);
      stroke_end <= stroke;
      if (load) begin
        ref_x <= drv_x_pos;
        ref_y <= drv_y_pos;
        sum_x <= SW'(drv_x_pos);
        sum_y <= SW'(drv_y_pos);
        n <= NW'(1);
        pen_down <= 1'b1;
      end
      if (add) begin
        sum_x <= sum_nx;
        sum_y <= sum_ny;
        n <= n + NW'(1);
      end
      if (stroke || take) n <= '0;
      if (stroke) pen_down <= 1'b0;
`ifdef TOUCH_SCALE_EN
      if (state == SCALE) begin
        pt_x <= ADC_W'((PW'(sum_x[SW-1:AVG_LOG2]) * PW'(SCREEN_W)) >> ADC_W);
        pt_y <= ADC_W'((PW'(sum_y[SW-1:AVG_LOG2]) * PW'(SCREEN_H)) >> ADC_W);
      end
`else
      if (add && last) begin
        pt_x <= sum_nx[SW-1:AVG_LOG2];
        pt_y <= sum_ny[SW-1:AVG_LOG2];
      end
`endif
    end
endmodule

// File: tb/tb_touch_sample_controller.sv
// tb_touch_sample_controller: directed checks of divider, averaging, outliers, backpressure, timeout and reset
module tb_touch_sample_controller;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic drv_pos_ready = 1'b0;
  logic pt_ready = 1'b0;
  logic [11:0] drv_x_pos = '0;
  logic [11:0] drv_y_pos = '0;
  logic drv_en, pt_valid, pen_down, stroke_end;
  logic [11:0] pt_x, pt_y;
  int n_cmp = 0;
  int n_bad = 0;
  int lat, cap_x, cap_y, nvalid, nstroke, first_se;
`ifdef TOUCH_SCALE_EN
  localparam int EXP_LAT = 2;
`else
  localparam int EXP_LAT = 1;
`endif

  touch_sample_controller #(
    .CLK_DIV(25),
    .AVG_LOG2(2),
    .MAX_DELTA(64),
    .IDLE_TIMEOUT(10)
  ) dut (
    .clk(clk),
    .reset(reset),
    .drv_en(drv_en),
    .drv_pos_ready(drv_pos_ready),
    .drv_x_pos(drv_x_pos),
    .drv_y_pos(drv_y_pos),
    .pt_valid(pt_valid),
    .pt_ready(pt_ready),
    .pt_x(pt_x),
    .pt_y(pt_y),
    .pen_down(pen_down),
    .stroke_end(stroke_end)
  );

  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int ex(input int a);
`ifdef TOUCH_SCALE_EN
    return (a * 240) >> 12;
`else
    return a;
`endif
  endfunction

  function automatic int ey(input int a);
`ifdef TOUCH_SCALE_EN
    return (a * 320) >> 12;
`else
    return a;
`endif
  endfunction

  task automatic send(input int x, input int y);
    drv_x_pos = 12'(x);
    drv_y_pos = 12'(y);
    drv_pos_ready = 1'b1;
    lat = 0;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      if (i == 1) drv_pos_ready = 1'b0;
      if (pt_valid) begin
        nvalid++;
        if (lat == 0) begin
          lat = i;
          cap_x = int'(pt_x);
          cap_y = int'(pt_y);
        end
      end
    end
  endtask

  initial begin
    int xs[6];
    xs = '{100, 100, 300, 300, 300, 300};
    repeat (3) @(negedge clk);
    check("rst_drv_en", drv_en, 0);
    check("rst_pt_valid", pt_valid, 0);
    check("rst_pen_down", pen_down, 0);
    check("rst_stroke_end", stroke_end, 0);
    check("rst_pt_x", pt_x, 0);
    reset = 1'b0;
    for (int k = 0; k < 100; k++) begin
      check($sformatf("drv_en_clk%0d", k), drv_en, int'(k % 25 == 24));
      @(negedge clk);
    end
    check("idle_pen_down", pen_down, 0);

    pt_ready = 1'b1;
    nvalid = 0;
    for (int i = 0; i < 4; i++) send(100 + 2 * i, 200);
    check("avg_latency", lat, EXP_LAT);
    check("avg_x", cap_x, ex(103));
    check("avg_y", cap_y, ey(200));
    check("avg_pen_down", pen_down, 1);
    check("avg_points", nvalid, 1);

    nvalid = 0;
    for (int i = 0; i < 6; i++) send(xs[i], 200);
    check("outlier_points", nvalid, 1);
    check("outlier_x", cap_x, ex(300));
    check("outlier_y", cap_y, ey(200));

    nvalid = 0;
    send(500, 700);
    send(564, 700);
    send(436, 636);
    send(500, 764);
    check("delta_edge_points", nvalid, 1);
    check("delta_edge_x", cap_x, ex(500));
    check("delta_edge_y", cap_y, ey(700));

    pt_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(400, 500);
    check("bp_valid", pt_valid, 1);
    check("bp_x", pt_x, ex(400));
    for (int i = 0; i < 4; i++) send(1000, 900);
    repeat (30) @(negedge clk);
    check("bp_hold_valid", pt_valid, 1);
    check("bp_hold_x", pt_x, ex(400));
    check("bp_hold_y", pt_y, ey(500));
    pt_ready = 1'b1;
    @(negedge clk);
    check("bp_release_valid", pt_valid, 0);
    check("bp_retain_x", pt_x, ex(400));
    nvalid = 0;
    for (int i = 0; i < 4; i++) send(800, 600);
    check("bp_next_points", nvalid, 1);
    check("bp_next_x", cap_x, ex(800));
    check("bp_next_y", cap_y, ey(600));

    check("se_pen_before", pen_down, 1);
    nstroke = 0;
    first_se = -1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (stroke_end) begin
        nstroke++;
        if (first_se < 0) first_se = i;
      end
    end
    check("se_pulses", nstroke, 1);
    check("se_timing_ok", int'(first_se >= 200 && first_se <= 260), 1);
    check("se_pen_after", pen_down, 0);

    nvalid = 0;
    for (int i = 0; i < 4; i++) send(2048, 4095);
    check("wide_latency", lat, EXP_LAT);
    check("wide_x", cap_x, ex(2048));
    check("wide_y", cap_y, ey(4095));
    check("wide_pen_down", pen_down, 1);

    pt_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(50, 60);
    check("rm_valid", pt_valid, 1);
    reset = 1'b1;
    @(negedge clk);
    check("rm_valid_drop", pt_valid, 0);
    check("rm_pen_down", pen_down, 0);
    reset = 1'b0;
    @(negedge clk);
    check("rm_no_stroke_end", stroke_end, 0);
    pt_ready = 1'b1;
    nvalid = 0;
    for (int i = 0; i < 4; i++) send(8, 12);
    check("rm_after_points", nvalid, 1);
    check("rm_after_x", cap_x, ex(8));
    check("rm_after_y", cap_y, ey(12));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
